// File: rtl/branch_predictor_gshare_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_gshare_if
// Description : Fetch-side and commit-side bundle of the gshare branch
//               predictor.
//               master : InstFetcher / ReorderBuffer side (drives fetch and
//                        commit, receives the prediction)
//               slave  : predictor side
//               Fetch  : IF_inst_valid, IF_inst, IF_inst_pc  -> predictor
//                        IF_need_jump, IF_predicted_imm, IF_ghr <- predictor
//               Commit : ROB_input_valid, ROB_taken, ROB_mispredict,
//                        ROB_pc, ROB_ghr -> predictor
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_gshare_if #(
  parameter int GHR_W = 8
);
  logic             IF_inst_valid;
  logic [31:0]      IF_inst;
  logic [31:0]      IF_inst_pc;
  logic             IF_need_jump;
  logic [31:0]      IF_predicted_imm;
  logic [GHR_W-1:0] IF_ghr;
  logic             ROB_input_valid;
  logic             ROB_taken;
  logic             ROB_mispredict;
  logic [31:0]      ROB_pc;
  logic [GHR_W-1:0] ROB_ghr;

  modport master (
    output IF_inst_valid, IF_inst, IF_inst_pc,
    output ROB_input_valid, ROB_taken, ROB_mispredict, ROB_pc, ROB_ghr,
    input  IF_need_jump, IF_predicted_imm, IF_ghr
  );

  modport slave (
    input  IF_inst_valid, IF_inst, IF_inst_pc,
    input  ROB_input_valid, ROB_taken, ROB_mispredict, ROB_pc, ROB_ghr,
    output IF_need_jump, IF_predicted_imm, IF_ghr
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_gshare
// Description : Two-level (gshare) branch predictor for the fetch stage.
//               Same-cycle taken/not-taken prediction and sign-extended
//               offset for InstFetcher. A table of CNT_W-bit saturating
//               counters is indexed by pc[PHT_IDX_W+1:2] XOR global history.
//               The speculative history advances on fetched B-type branches
//               and is repaired from the ROB on a misprediction; training at
//               commit uses the history snapshot carried with the branch.
// Ports       : clk   - clock
//               rst   - synchronous active-high reset
//               rdy   - global ready; all state frozen while low
//               bp_if - branch_predictor_gshare_if.slave (fetch + commit)
// Config      : GSHARE_PREDICTOR_EN defined   -> gshare indexing and history
//               GSHARE_PREDICTOR_EN undefined -> bimodal (PC-only index,
//                                                history held at zero)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_gshare #(
  parameter int PHT_IDX_W = 8,
  parameter int GHR_W     = 8,
  parameter int CNT_W     = 2
) (
  input  wire                         clk,
  input  wire                         rst,
  input  wire                         rdy,
  branch_predictor_gshare_if.slave    bp_if
);

  localparam int               c_PHT_N    = 1 << PHT_IDX_W;
  localparam logic [6:0]       c_OP_JAL   = 7'b1101111;
  localparam logic [6:0]       c_OP_BR    = 7'b1100011;
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CNT_W-1:0] c_CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};

  logic [CNT_W-1:0]     r_pht [c_PHT_N];
  logic [GHR_W-1:0]     r_spec_ghr;

  logic [GHR_W-1:0]     w_ghr_next;
  logic [PHT_IDX_W-1:0] w_pred_hist;
  logic [PHT_IDX_W-1:0] w_trn_hist;
  logic [PHT_IDX_W-1:0] w_pred_idx;
  logic [PHT_IDX_W-1:0] w_trn_idx;
  logic [CNT_W-1:0]     w_pred_cnt;
  logic [CNT_W-1:0]     w_trn_old;
  logic [CNT_W-1:0]     w_trn_new;
  logic [6:0]           w_opcode;
  logic                 w_is_jal;
  logic                 w_is_br;
  logic                 w_need_jump;
  logic [31:0]          w_imm_j;
  logic [31:0]          w_imm_b;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  assign w_opcode = bp_if.IF_inst[6:0];
  assign w_is_jal = (w_opcode == c_OP_JAL);
  assign w_is_br  = (w_opcode == c_OP_BR);

  assign w_imm_j = {{11{bp_if.IF_inst[31]}}, bp_if.IF_inst[31], bp_if.IF_inst[19:12],
                    bp_if.IF_inst[20], bp_if.IF_inst[30:21], 1'b0};
  assign w_imm_b = {{19{bp_if.IF_inst[31]}}, bp_if.IF_inst[31], bp_if.IF_inst[7],
                    bp_if.IF_inst[30:25], bp_if.IF_inst[11:8], 1'b0};

  // --------------------------------------------------------------------------
  // History handling
  // --------------------------------------------------------------------------
`ifdef GSHARE_PREDICTOR_EN
  logic [GHR_W-1:0] w_ghr_shift;
  logic [GHR_W-1:0] w_ghr_repair;

  generate
    if (GHR_W == 1) begin : g_ghr_w1
      assign w_ghr_shift  = w_need_jump;
      assign w_ghr_repair = bp_if.ROB_taken;
    end else begin : g_ghr_wn
      assign w_ghr_shift  = {r_spec_ghr[GHR_W-2:0], w_need_jump};
      assign w_ghr_repair = {bp_if.ROB_ghr[GHR_W-2:0], bp_if.ROB_taken};
    end
  endgenerate

  // Repair overrides a same-cycle fetch shift: that fetch is being flushed.
  always_comb begin
    w_ghr_next = r_spec_ghr;
    if (bp_if.IF_inst_valid && w_is_br) begin
      w_ghr_next = w_ghr_shift;
    end
    if (bp_if.ROB_input_valid && bp_if.ROB_mispredict) begin
      w_ghr_next = w_ghr_repair;
    end
  end

  assign w_pred_hist = PHT_IDX_W'(r_spec_ghr);
  assign w_trn_hist  = PHT_IDX_W'(bp_if.ROB_ghr);
`else
  // Bimodal: history never leaves zero, ROB snapshot and mispredict unused.
  logic w_unused_bimodal;
  assign w_unused_bimodal = ^{bp_if.ROB_ghr, bp_if.ROB_mispredict};

  assign w_ghr_next  = '0;
  assign w_pred_hist = '0;
  assign w_trn_hist  = '0;
`endif

  // --------------------------------------------------------------------------
  // Table index / read
  // --------------------------------------------------------------------------
  assign w_pred_idx = bp_if.IF_inst_pc[PHT_IDX_W+1:2] ^ w_pred_hist;
  assign w_trn_idx  = bp_if.ROB_pc[PHT_IDX_W+1:2]     ^ w_trn_hist;

  // Read is from the registered table, so a same-cycle commit to the same
  // entry is seen only from the next cycle on.
  assign w_pred_cnt = r_pht[w_pred_idx];
  assign w_trn_old  = r_pht[w_trn_idx];

  // Saturating update, no wrap at either bound.
  always_comb begin
    w_trn_new = w_trn_old;
    if (bp_if.ROB_taken) begin
      if (w_trn_old != c_CNT_MAX) begin
        w_trn_new = w_trn_old + CNT_W'(1);
      end
    end else begin
      if (w_trn_old != '0) begin
        w_trn_new = w_trn_old - CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Prediction outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_need_jump = 1'b0;
    if (w_is_jal) begin
      w_need_jump = 1'b1;
    end else if (w_is_br) begin
      w_need_jump = w_pred_cnt[CNT_W-1];
    end
  end

  assign bp_if.IF_need_jump     = w_need_jump;
  assign bp_if.IF_predicted_imm = w_is_br ? w_imm_b : w_imm_j;
  assign bp_if.IF_ghr           = r_spec_ghr;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_PHT_N; i++) begin
        r_pht[i] <= c_CNT_INIT;
      end
      r_spec_ghr <= '0;
    end else if (rdy) begin
      if (bp_if.ROB_input_valid) begin
        r_pht[w_trn_idx] <= w_trn_new;
      end
      r_spec_ghr <= w_ghr_next;
    end
  end

  // PC bits outside the index field do not take part in prediction.
  logic w_unused_pc_bits;
  assign w_unused_pc_bits = ^{bp_if.IF_inst_pc[1:0], bp_if.IF_inst_pc[31:PHT_IDX_W+2],
                              bp_if.ROB_pc[1:0], bp_if.ROB_pc[31:PHT_IDX_W+2]};

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor_gshare
// Description : Self-checking bench for branch_predictor_gshare with default
//               parameters (PHT_IDX_W=8, GHR_W=8, CNT_W=2). Each vector holds
//               the fetch/commit inputs for one cycle plus the expected
//               prediction for both gshare and bimodal builds; the record is
//               queued when driven and popped when the outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_gshare;

`ifdef GSHARE_PREDICTOR_EN
  localparam bit c_GSHARE = 1'b1;
`else
  localparam bit c_GSHARE = 1'b0;
`endif

  localparam logic [31:0] c_B   = 32'h0000_0463;  // beq x0,x0,+8
  localparam logic [31:0] c_BN  = 32'hFE00_0EE3;  // beq x0,x0,-4
  localparam logic [31:0] c_J   = 32'h0080_006F;  // jal x0,+8
  localparam logic [31:0] c_A   = 32'h0010_0093;  // addi x1,x0,1
  localparam logic [31:0] c_P8  = 32'h0000_0008;
  localparam logic [31:0] c_M4  = 32'hFFFF_FFFC;

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          fv;
    logic [31:0] inst;
    logic [31:0] pc;
    bit          rv;
    bit          rt;
    bit          rm;
    logic [31:0] rpc;
    logic [7:0]  rghr;
    bit          chk;
    bit          nj_g;
    logic [7:0]  ghr_g;
    bit          nj_b;
    bit          chk_imm;
    logic [31:0] imm;
  } vec_t;

  logic clk;
  logic rst;
  logic rdy;

  branch_predictor_gshare_if #(.GHR_W(8)) bp_if ();

  branch_predictor_gshare #(
    .PHT_IDX_W (8),
    .GHR_W     (8),
    .CNT_W     (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .bp_if (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks;
  int   failures;
  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(bit i_rst, bit i_rdy, bit i_fv, logic [31:0] i_inst,
                              logic [31:0] i_pc, bit i_rv, bit i_rt, bit i_rm,
                              logic [31:0] i_rpc, logic [7:0] i_rghr, bit i_chk,
                              bit i_nj_g, logic [7:0] i_ghr_g, bit i_nj_b,
                              bit i_chk_imm, logic [31:0] i_imm);
    vec_t v;
    v.rst = i_rst; v.rdy = i_rdy; v.fv = i_fv; v.inst = i_inst; v.pc = i_pc;
    v.rv = i_rv; v.rt = i_rt; v.rm = i_rm; v.rpc = i_rpc; v.rghr = i_rghr;
    v.chk = i_chk; v.nj_g = i_nj_g; v.ghr_g = i_ghr_g; v.nj_b = i_nj_b;
    v.chk_imm = i_chk_imm; v.imm = i_imm;
    return v;
  endfunction

  task automatic check_out(input vec_t e, input int n);
    logic       exp_nj;
    logic [7:0] exp_ghr;
    exp_nj  = c_GSHARE ? e.nj_g  : e.nj_b;
    exp_ghr = c_GSHARE ? e.ghr_g : 8'h00;
    checks++;
    if (bp_if.IF_need_jump !== exp_nj) begin
      failures++;
      $display("FAIL vec%0d need_jump: got %b expected %b", n, bp_if.IF_need_jump, exp_nj);
    end
    checks++;
    if (bp_if.IF_ghr !== exp_ghr) begin
      failures++;
      $display("FAIL vec%0d ghr: got %h expected %h", n, bp_if.IF_ghr, exp_ghr);
    end
    if (e.chk_imm) begin
      checks++;
      if (bp_if.IF_predicted_imm !== e.imm) begin
        failures++;
        $display("FAIL vec%0d imm: got %h expected %h", n, bp_if.IF_predicted_imm, e.imm);
      end
    end
  endtask

  // One cycle: drive, queue expectation, sample on the falling edge, advance.
  task automatic apply(input vec_t v, input int n);
    vec_t e;
    rst                   = v.rst;
    rdy                   = v.rdy;
    bp_if.IF_inst_valid   = v.fv;
    bp_if.IF_inst         = v.inst;
    bp_if.IF_inst_pc      = v.pc;
    bp_if.ROB_input_valid = v.rv;
    bp_if.ROB_taken       = v.rt;
    bp_if.ROB_mispredict  = v.rm;
    bp_if.ROB_pc          = v.rpc;
    bp_if.ROB_ghr         = v.rghr;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    if (e.chk) check_out(e, n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //          rst rdy fv inst  pc        rv rt rm rpc       rghr   chk njg ghrg   njb ci imm
    // Reset, then first B-type at 0x100: weakly not-taken, history zero.
    vecs.push_back(mk(1, 1, 1, c_B,  32'h100, 0, 0, 0, 32'h0,   8'h00, 0, 0, 8'h00, 0, 0, c_P8));
    vecs.push_back(mk(0, 1, 1, c_B,  32'h100, 0, 0, 0, 32'h0,   8'h00, 1, 0, 8'h00, 0, 1, c_P8));
    // Two taken commits 01->10->11; same-cycle read sees the old value.
    vecs.push_back(mk(0, 1, 0, c_B,  32'h100, 1, 1, 0, 32'h100, 8'h00, 1, 0, 8'h00, 0, 1, c_P8));
    vecs.push_back(mk(0, 1, 0, c_B,  32'h100, 1, 1, 0, 32'h100, 8'h00, 1, 1, 8'h00, 1, 1, c_P8));
    // Third taken commit saturates at 11, one not-taken leaves 10.
    vecs.push_back(mk(0, 1, 0, c_B,  32'h100, 1, 1, 0, 32'h100, 8'h00, 1, 1, 8'h00, 1, 0, c_P8));
    vecs.push_back(mk(0, 1, 0, c_B,  32'h100, 0, 0, 0, 32'h0,   8'h00, 1, 1, 8'h00, 1, 0, c_P8));
    vecs.push_back(mk(0, 1, 0, c_B,  32'h100, 1, 0, 0, 32'h100, 8'h00, 1, 1, 8'h00, 1, 0, c_P8));
    vecs.push_back(mk(0, 1, 0, c_B,  32'h100, 0, 0, 0, 32'h0,   8'h00, 1, 1, 8'h00, 1, 0, c_P8));
    // History: T, N, (JAL), T -> 00, 01, 02, 02, then 05.
    vecs.push_back(mk(0, 1, 1, c_B,  32'h100, 0, 0, 0, 32'h0,   8'h00, 1, 1, 8'h00, 1, 0, c_P8));
    vecs.push_back(mk(0, 1, 1, c_B,  32'h200, 0, 0, 0, 32'h0,   8'h00, 1, 0, 8'h01, 0, 0, c_P8));
    vecs.push_back(mk(0, 1, 1, c_J,  32'h300, 0, 0, 0, 32'h0,   8'h00, 1, 1, 8'h02, 1, 1, c_P8));
    vecs.push_back(mk(0, 1, 1, c_B,  32'h108, 0, 0, 0, 32'h0,   8'h00, 1, 1, 8'h02, 0, 0, c_P8));
    vecs.push_back(mk(0, 1, 0, c_BN, 32'h100, 0, 0, 0, 32'h0,   8'h00, 1, 0, 8'h05, 1, 1, c_M4));
    // Repair to 0x5A, then repair with 0x33/taken beside a fetched branch -> 0x67.
    vecs.push_back(mk(0, 1, 0, c_B,  32'h100, 1, 0, 1, 32'h400, 8'h2D, 1, 0, 8'h05, 1, 0, c_P8));
    vecs.push_back(mk(0, 1, 1, c_B,  32'h100, 1, 1, 1, 32'h600, 8'h33, 1, 0, 8'h5A, 1, 0, c_P8));
    vecs.push_back(mk(0, 1, 0, c_B,  32'h100, 0, 0, 0, 32'h0,   8'h00, 1, 0, 8'h67, 1, 0, c_P8));
    // Alias: drop entry 0x40 to 00, train 0x41 via pc 0x104/ghr 0, history -> 01.
    vecs.push_back(mk(0, 1, 0, c_B,  32'h100, 1, 0, 1, 32'h800, 8'h00, 1, 0, 8'h67, 1, 0, c_P8));
    vecs.push_back(mk(0, 1, 0, c_B,  32'h104, 1, 0, 0, 32'h100, 8'h00, 1, 0, 8'h00, 0, 0, c_P8));
    vecs.push_back(mk(0, 1, 0, c_B,  32'h104, 1, 0, 0, 32'h100, 8'h00, 1, 0, 8'h00, 0, 0, c_P8));
    vecs.push_back(mk(0, 1, 0, c_B,  32'h104, 1, 1, 1, 32'h104, 8'h00, 1, 0, 8'h00, 0, 0, c_P8));
    vecs.push_back(mk(0, 1, 0, c_B,  32'h100, 0, 0, 0, 32'h0,   8'h00, 1, 1, 8'h01, 0, 0, c_P8));

    foreach (vecs[i]) apply(vecs[i], i);

    // rdy low: a commit that would untrain entry 0x41 and repair history,
    // plus a fetched branch, must all be ignored.
    for (int k = 0; k < 2; k++)
      apply(mk(0, 0, 1, c_B, 32'h100, 1, 0, 1, 32'h144, 8'h10, 1, 1, 8'h01, 0, 0, c_P8), 100 + k);
    apply(mk(0, 1, 0, c_B, 32'h100, 0, 0, 0, 32'h0, 8'h00, 1, 1, 8'h01, 0, 0, c_P8), 102);

    // Reset mid-run beats a same-cycle repair/training.
    apply(mk(1, 1, 0, c_B,  32'h100, 1, 1, 1, 32'h100, 8'h00, 1, 1, 8'h01, 0, 0, c_P8), 103);
    apply(mk(0, 1, 0, c_B,  32'h100, 0, 0, 0, 32'h0,   8'h00, 1, 0, 8'h00, 0, 1, c_P8), 104);
    apply(mk(0, 1, 0, c_BN, 32'h104, 0, 0, 0, 32'h0,   8'h00, 1, 0, 8'h00, 0, 1, c_M4), 105);
    apply(mk(0, 1, 1, c_A,  32'h100, 0, 0, 0, 32'h0,   8'h00, 1, 0, 8'h00, 0, 0, c_P8), 106);
    apply(mk(0, 1, 0, c_J,  32'h104, 0, 0, 0, 32'h0,   8'h00, 1, 1, 8'h00, 1, 1, c_P8), 107);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
